// File: rtl/ctrl_frame_injector.sv
// Transmit-side control frame injector: the CPU fills a 4-slot frame queue over iomem and commits
// each frame through cfg; a drain engine writes the body, then the flagged header, into the switch FIFOs.
module ctrl_frame_injector #(
  parameter int HEADER_DWIDTH = 128,
  parameter int MAX_BODY      = 48
) (
  input  logic                     clk,
  input  logic                     arst_n,
  output logic [HEADER_DWIDTH-1:0] h_fifo_din,
  output logic                     h_fifo_wren,
  input  logic                     h_fifo_full,
  output logic [7:0]               b_fifo_din,
  output logic                     b_fifo_wren,
  output logic                     b_fifo_del,
  input  logic                     b_fifo_full,
  input  logic                     iomem_valid,
  output logic                     iomem_ready,
  input  logic [3:0]               iomem_wstrb,
  input  logic [31:0]              iomem_addr,
  input  logic [31:0]              iomem_wdata,
  output logic [31:0]              iomem_rdata,
  input  logic [3:0]               cfg_we,
  input  logic [31:0]              cfg_di,
  output logic [31:0]              cfg_do
);

  localparam logic [5:0] LP_MAX_LEN = 6'(MAX_BODY);
  localparam logic [HEADER_DWIDTH-1:0] LP_CTRL_FLAG = {{(HEADER_DWIDTH-1){1'b0}}, 1'b1} << 114;

  typedef enum logic [2:0] {
    S_IDLE,
    S_HDR,
    S_LOAD,
    S_EMIT,
    S_HWR
  } state_t;

  state_t                   r_state;
  state_t                   w_state_nxt;
  logic [31:0]              r_mem [0:63];
  logic [5:0]               r_slot_len [0:3];
  logic [2:0]               r_wr_slot;
  logic [2:0]               r_rd_slot;
  logic                     r_error;
  logic [5:0]               r_last_len;
  logic                     r_iomem_ready;
  logic [31:0]              r_iomem_rdata;
  logic [31:0]              r_rd_q;
  logic [HEADER_DWIDTH-1:0] r_hdr;
  logic                     r_hdr_shift;
  logic [3:0]               r_wcnt;
  logic [1:0]               r_byte_idx;
  logic [5:0]               r_byte_cnt;

  logic       w_empty;
  logic       w_full;
  logic [2:0] w_count;
  logic [5:0] w_cur_len;
  logic [5:0] w_len;
  logic       w_len_ok;
  logic       w_commit;
  logic       w_commit_bad;
  logic       w_err_clr;
  logic       w_io_fire;
  logic [5:0] w_io_word;
  logic       w_rd_en;
  logic [5:0] w_rd_addr;
  logic       w_last;
  logic       w_unused;

  assign w_empty   = (r_wr_slot == r_rd_slot);
  assign w_full    = (r_wr_slot[1:0] == r_rd_slot[1:0]) && (r_wr_slot[2] != r_rd_slot[2]);
  assign w_count   = r_wr_slot - r_rd_slot;
  assign w_cur_len = r_slot_len[r_rd_slot[1:0]];

  assign w_len        = cfg_di[5:0];
  assign w_len_ok     = (w_len != 6'd0) && (w_len <= LP_MAX_LEN);
  assign w_commit     = cfg_we[3] & cfg_di[30] & ~w_full & w_len_ok;
  assign w_commit_bad = cfg_we[3] & cfg_di[30] & ~w_commit;
  assign w_err_clr    = cfg_we[3] & cfg_di[27];

  // The CPU holds valid through the ready cycle, so only the first sampled cycle acts.
  assign w_io_fire = iomem_valid & ~r_iomem_ready;
  assign w_io_word = {r_wr_slot[1:0], iomem_addr[5:2]};

  assign w_rd_addr = {r_rd_slot[1:0], r_wcnt};
  assign w_last    = (r_byte_cnt == w_cur_len - 6'd1);

  assign iomem_ready = r_iomem_ready;
  assign iomem_rdata = r_iomem_rdata;
  assign cfg_do      = {w_full, 1'b0, (r_state != S_IDLE), 1'b0, r_error, w_count, 18'd0, r_last_len};

  assign w_unused = ^{cfg_we[2:0], cfg_di[31], cfg_di[29:28], cfg_di[26:6],
                      iomem_addr[31:6], iomem_addr[1:0]};

  // NOTE: the frame RAM and per-slot lengths carry no reset; the pointers alone define valid content.
  always_ff @(posedge clk) begin
    if (w_io_fire) begin
      for (int b = 0; b < 4; b++) begin
        if (iomem_wstrb[b]) r_mem[w_io_word][8*b +: 8] <= iomem_wdata[8*b +: 8];
      end
    end
    if (w_commit) r_slot_len[r_wr_slot[1:0]] <= w_len;
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (!arst_n) r_state <= S_IDLE;
    else         r_state <= w_state_nxt;
  end

  // NOTE: every output and next-state signal gets a default first so no latch is inferred.
  always_comb begin
    w_state_nxt = r_state;
    w_rd_en     = 1'b0;
    b_fifo_wren = 1'b0;
    b_fifo_del  = 1'b0;
    h_fifo_wren = 1'b0;
    h_fifo_din  = '0;
    unique case (r_byte_idx)
      2'd0:    b_fifo_din = r_rd_q[31:24];
      2'd1:    b_fifo_din = r_rd_q[23:16];
      2'd2:    b_fifo_din = r_rd_q[15:8];
      default: b_fifo_din = r_rd_q[7:0];
    endcase
    unique case (r_state)
      S_IDLE: if (!w_empty) w_state_nxt = S_HDR;
      S_HDR: begin
        w_rd_en = 1'b1;
        if (r_wcnt == 4'd3) w_state_nxt = S_LOAD;
      end
      S_LOAD: begin
        w_rd_en     = 1'b1;
        w_state_nxt = S_EMIT;
      end
      S_EMIT: begin
        if (!b_fifo_full) begin
          b_fifo_wren = 1'b1;
          b_fifo_del  = w_last;
          if (w_last)                  w_state_nxt = S_HWR;
          else if (r_byte_idx == 2'd3) w_state_nxt = S_LOAD;
        end
      end
      S_HWR: begin
        h_fifo_din = r_hdr | LP_CTRL_FLAG;
        if (!h_fifo_full) begin
          h_fifo_wren = 1'b1;
          w_state_nxt = S_IDLE;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!arst_n) begin
      r_wr_slot     <= '0;
      r_rd_slot     <= '0;
      r_error       <= 1'b0;
      r_last_len    <= '0;
      r_iomem_ready <= 1'b0;
      r_iomem_rdata <= '0;
      r_rd_q        <= '0;
      r_hdr         <= '0;
      r_hdr_shift   <= 1'b0;
      r_wcnt        <= '0;
      r_byte_idx    <= '0;
      r_byte_cnt    <= '0;
    end else begin
      r_iomem_ready <= w_io_fire;
      if (w_io_fire) r_iomem_rdata <= r_mem[w_io_word];

      if (w_commit) begin
        r_wr_slot  <= r_wr_slot + 3'd1;
        r_last_len <= w_len;
      end
      if (w_commit_bad)   r_error <= 1'b1;
      else if (w_err_clr) r_error <= 1'b0;
      if (h_fifo_wren) r_rd_slot <= r_rd_slot + 3'd1;

      // Header words return one cycle after each S_HDR read and shift in MSW first.
      if (w_rd_en) r_rd_q <= r_mem[w_rd_addr];
      r_hdr_shift <= (r_state == S_HDR);
      if (r_hdr_shift) r_hdr <= {r_hdr[HEADER_DWIDTH-33:0], r_rd_q};

      unique case (r_state)
        S_IDLE: begin
          r_wcnt     <= '0;
          r_byte_cnt <= '0;
        end
        S_HDR: r_wcnt <= r_wcnt + 4'd1;
        S_LOAD: begin
          r_wcnt     <= r_wcnt + 4'd1;
          r_byte_idx <= '0;
        end
        S_EMIT: begin
          if (b_fifo_wren) begin
            r_byte_cnt <= r_byte_cnt + 6'd1;
            r_byte_idx <= r_byte_idx + 2'd1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
